// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares port b of the CPU register file between the CPU execute stage and
// the host debug interface. Each won request is registered and drives port b
// for exactly one cycle (ACCESS). The read value is captured at the end of
// that cycle and returned with a done pulse. The CPU has priority; a hold
// counter lets debug through after HOLD_MAX consecutive CPU wins. Writes to
// the FLAG register (address 31) are suppressed and flagged on err.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cpu_req/addr/wr/wdata   CPU request (level) and its fields
//   cpu_gnt, cpu_done       CPU grant (access cycle) and completion pulse
//   dbg_req/addr/wr/wdata   debug request (level) and its fields
//   dbg_gnt, dbg_done       debug grant and completion pulse
//   rdata, err              captured read data, blocked-FLAG-write flag
//   b_addr, b_data_in, b_wr_enable, b_data_out   register file port b
//   busy                    high while in ACCESS
module regfile_port_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic [4:0] cpu_addr,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_done,
    input  logic       dbg_req,
    input  logic [4:0] dbg_addr,
    input  logic       dbg_wr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_gnt,
    output logic       dbg_done,
    output logic [7:0] rdata,
    output logic       err,
    output logic [4:0] b_addr,
    output logic [7:0] b_data_in,
    output logic       b_wr_enable,
    input  logic [7:0] b_data_out,
    output logic       busy
);

    localparam logic [4:0] FLAG_ADDR = 5'd31;
    localparam logic [3:0] HOLD_LIM  = 4'(HOLD_MAX);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t     r_state;
    logic [3:0] r_hold_cnt;
    logic [4:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_wr;
    logic       r_win_dbg;
    logic       r_cpu_gnt;
    logic       r_dbg_gnt;
    logic       r_cpu_done;
    logic       r_dbg_done;
    logic [7:0] r_rdata;
    logic       r_err;
    logic       r_we;

    logic       w_hold_sat;
    logic       w_cpu_win;
    logic       w_dbg_win;
    logic [4:0] w_win_addr;
    logic [7:0] w_win_wdata;
    logic       w_win_wr;

    // Debug overrides CPU priority only once the CPU has been granted
    // HOLD_MAX times in a row while debug was waiting.
    assign w_hold_sat  = (r_hold_cnt == HOLD_LIM);
    assign w_cpu_win   = cpu_req & ~(dbg_req & w_hold_sat);
    assign w_dbg_win   = dbg_req & ~w_cpu_win;
    assign w_win_addr  = w_cpu_win ? cpu_addr  : dbg_addr;
    assign w_win_wdata = w_cpu_win ? cpu_wdata : dbg_wdata;
    assign w_win_wr    = w_cpu_win ? cpu_wr    : dbg_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_win_dbg  <= 1'b0;
            r_cpu_gnt  <= 1'b0;
            r_dbg_gnt  <= 1'b0;
            r_cpu_done <= 1'b0;
            r_dbg_done <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            // Completion of the access driven during the cycle now ending.
            // b_data_out still shows the pre-write value here.
            if (r_state == ACCESS) begin
                r_rdata    <= b_data_out;
                r_cpu_done <= ~r_win_dbg;
                r_dbg_done <= r_win_dbg;
                r_err      <= r_wr & (r_addr == FLAG_ADDR);
            end else begin
                r_cpu_done <= 1'b0;
                r_dbg_done <= 1'b0;
            end

            // Arbitration runs every edge so accesses can chain back-to-back.
            if (w_cpu_win || w_dbg_win) begin
                r_state   <= ACCESS;
                r_addr    <= w_win_addr;
                r_wdata   <= w_win_wdata;
                r_wr      <= w_win_wr;
                r_win_dbg <= w_dbg_win;
                r_cpu_gnt <= w_cpu_win;
                r_dbg_gnt <= w_dbg_win;
                r_we      <= w_win_wr & (w_win_addr != FLAG_ADDR);
            end else begin
                r_state   <= IDLE;
                r_cpu_gnt <= 1'b0;
                r_dbg_gnt <= 1'b0;
                r_we      <= 1'b0;
            end

            if (!dbg_req || w_dbg_win) begin
                r_hold_cnt <= '0;
            end else if (!w_hold_sat) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
        end
    end

    assign cpu_gnt     = r_cpu_gnt;
    assign dbg_gnt     = r_dbg_gnt;
    assign cpu_done    = r_cpu_done;
    assign dbg_done    = r_dbg_done;
    assign rdata       = r_rdata;
    assign err         = r_err;
    assign b_addr      = r_addr;
    assign b_data_in   = r_wdata;
    assign b_wr_enable = r_we;
    assign busy        = (r_state == ACCESS);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
// Directed table vectors, a starvation/reset sequence and a randomized phase
// checked against a transaction-level reference model. A behavioural
// register file is attached to port b.
module tb_regfile_port_arbiter;

    localparam int HOLD_MAX = 4;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_wr, cpu_gnt, cpu_done;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       dbg_req, dbg_wr, dbg_gnt, dbg_done;
    logic [4:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic [7:0] rdata;
    logic       err;
    logic [4:0] b_addr;
    logic [7:0] b_data_in;
    logic       b_wr_enable;
    logic [7:0] b_data_out;
    logic       busy;

    regfile_port_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
        .rdata(rdata), .err(err),
        .b_addr(b_addr), .b_data_in(b_data_in), .b_wr_enable(b_wr_enable),
        .b_data_out(b_data_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file on port b: asynchronous read, write at edge.
    logic [7:0] rf [32];
    assign b_data_out = rf[b_addr];

    logic [27:0] w_act;
    assign w_act = {cpu_gnt, dbg_gnt, cpu_done, dbg_done, busy, b_wr_enable, err,
                    rdata, b_addr, b_data_in};

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] mmem [32];
    logic       m_pend;          // an access is being driven on port b
    logic       m_pend_dbg;
    logic [4:0] m_pend_addr;
    logic       m_pend_wr;
    logic [7:0] m_pend_wdata;
    int         m_cpu_streak;    // CPU wins while debug waited
    logic       e_cg, e_dg, e_cd, e_dd, e_busy, e_we, e_err;
    logic [7:0] e_rdata, e_bdin;
    logic [4:0] e_baddr;

    function automatic logic [27:0] model_vec();
        return {e_cg, e_dg, e_cd, e_dd, e_busy, e_we, e_err, e_rdata, e_baddr, e_bdin};
    endfunction

    task automatic model_edge();
        logic debug_turn, take_cpu, take_dbg;
        if (m_pend && m_pend_wr && m_pend_addr != 5'd31) begin
            e_rdata = mmem[m_pend_addr];
            mmem[m_pend_addr] = m_pend_wdata;
        end else if (m_pend) begin
            e_rdata = mmem[m_pend_addr];
        end
        if (reset) begin
            m_pend = 1'b0; m_cpu_streak = 0;
            {e_cg, e_dg, e_cd, e_dd, e_busy, e_we, e_err} = '0;
            e_rdata = '0; e_baddr = '0; e_bdin = '0;
        end else begin
            e_cd = m_pend && !m_pend_dbg;
            e_dd = m_pend && m_pend_dbg;
            if (m_pend) e_err = m_pend_wr && (m_pend_addr == 5'd31);
            debug_turn = dbg_req && (m_cpu_streak >= HOLD_MAX);
            take_cpu = cpu_req && !debug_turn;
            take_dbg = dbg_req && !take_cpu;
            if (take_cpu && dbg_req) m_cpu_streak = (m_cpu_streak < HOLD_MAX) ? m_cpu_streak + 1 : HOLD_MAX;
            else m_cpu_streak = 0;
            m_pend = take_cpu || take_dbg;
            e_cg = take_cpu; e_dg = take_dbg; e_busy = m_pend;
            if (m_pend) begin
                m_pend_dbg   = take_dbg;
                m_pend_addr  = take_cpu ? cpu_addr  : dbg_addr;
                m_pend_wr    = take_cpu ? cpu_wr    : dbg_wr;
                m_pend_wdata = take_cpu ? cpu_wdata : dbg_wdata;
                e_baddr = m_pend_addr; e_bdin = m_pend_wdata;
                e_we = m_pend_wr && (m_pend_addr != 5'd31);
            end else begin
                e_we = 1'b0;
            end
        end
    endtask

    // One clock: model sees the same pre-edge inputs, outputs settle #1 after.
    task automatic step();
        logic       we;
        logic [4:0] a;
        logic [7:0] d;
        model_edge();
        we = b_wr_enable; a = b_addr; d = b_data_in;
        @(posedge clk);
        #1;
        if (we) rf[a] = d;
    endtask

    task automatic check(input string name, input int idx, input logic [27:0] act,
                         input logic [27:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got {cg,dg,cd,dd,busy,we,err,rdata,baddr,bdin}=%h want %h",
                     name, idx, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       creq;  logic [4:0] caddr; logic cwr; logic [7:0] cwd;
        logic       dreq;  logic [4:0] daddr; logic dwr; logic [7:0] dwd;
        logic [27:0] exp;
    } vec_t;

    function automatic vec_t mk(input int rst, input int creq, input int caddr, input int cwr,
                                input int cwd, input int dreq, input int daddr, input int dwr,
                                input int dwd, input int cg, input int dg, input int cd,
                                input int dd, input int bsy, input int we, input int er,
                                input int rd, input int ba, input int bd);
        vec_t v;
        v.rst = 1'(rst); v.creq = 1'(creq); v.caddr = 5'(caddr); v.cwr = 1'(cwr);
        v.cwd = 8'(cwd); v.dreq = 1'(dreq); v.daddr = 5'(daddr); v.dwr = 1'(dwr);
        v.dwd = 8'(dwd);
        v.exp = {1'(cg), 1'(dg), 1'(cd), 1'(dd), 1'(bsy), 1'(we), 1'(er), 8'(rd), 5'(ba), 8'(bd)};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst;
        cpu_req = v.creq; cpu_addr = v.caddr; cpu_wr = v.cwr; cpu_wdata = v.cwd;
        dbg_req = v.dreq; dbg_addr = v.daddr; dbg_wr = v.dwr; dbg_wdata = v.dwd;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    vec_t tbl [15];

    initial begin
        //             rst cq ca cw cwd   dq da dw dwd  cg dg cd dd by we er rdata ba bdin
        tbl[0]  = mk(1, 1, 5, 1, 'hA5, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 'h00,  0, 'h00);
        tbl[1]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 'h00,  0, 'h00);
        tbl[2]  = mk(0, 1, 5, 1, 'hA5, 0, 0, 0, 0,    1, 0, 0, 0, 1, 1, 0, 'h00,  5, 'hA5);
        tbl[3]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 'h55,  5, 'hA5);
        tbl[4]  = mk(0, 1, 5, 0, 0,    0, 0, 0, 0,    1, 0, 0, 0, 1, 0, 0, 'h55,  5, 'h00);
        tbl[5]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 'hA5,  5, 'h00);
        tbl[6]  = mk(0, 0, 0, 0, 0,    1, 31, 1, 'hFF, 0, 1, 0, 0, 1, 0, 0, 'hA5, 31, 'hFF);
        tbl[7]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 1, 0, 0, 1, 'h0F, 31, 'hFF);
        tbl[8]  = mk(0, 1, 1, 0, 0,    0, 0, 0, 0,    1, 0, 0, 0, 1, 0, 1, 'h0F,  1, 'h00);
        tbl[9]  = mk(0, 1, 2, 0, 0,    0, 0, 0, 0,    1, 0, 1, 0, 1, 0, 0, 'h11,  2, 'h00);
        tbl[10] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 'h22,  2, 'h00);
        tbl[11] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 'h22,  2, 'h00);
        tbl[12] = mk(0, 0, 0, 0, 0,    1, 3, 0, 0,    0, 1, 0, 0, 1, 0, 0, 'h22,  3, 'h00);
        tbl[13] = mk(1, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 'h00,  0, 'h00);
        tbl[14] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 'h00,  0, 'h00);

        for (int i = 0; i < 32; i++) begin
            rf[i]   = 8'(i * 17);
            mmem[i] = 8'(i * 17);
        end
        m_pend = 1'b0; m_pend_dbg = 1'b0; m_pend_addr = '0; m_pend_wr = 1'b0;
        m_pend_wdata = '0; m_cpu_streak = 0;
        {e_cg, e_dg, e_cd, e_dd, e_busy, e_we, e_err} = '0;
        e_rdata = '0; e_baddr = '0; e_bdin = '0;
        cpu_addr = '0; cpu_wr = 1'b0; cpu_wdata = '0;
        dbg_addr = '0; dbg_wr = 1'b0; dbg_wdata = '0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
            step();
            check("table", i, w_act, tbl[i].exp);
        end

        // Starvation guard: both requesting continuously.
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 5'd7; cpu_wr = 1'b0;
        dbg_req = 1'b1; dbg_addr = 5'd8; dbg_wr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("starve_gnt", k, {26'd0, cpu_gnt, dbg_gnt},
                  {26'd0, (k % 5 == 4) ? 2'b01 : 2'b10});
        end
        // Build up CPU streak, then reset; the streak must restart from zero.
        step();
        step();
        reset = 1'b1;
        step();
        check("reset_mid", 0, w_act, 28'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_reset_gnt", k, {26'd0, cpu_gnt, dbg_gnt},
                  {26'd0, (k == 4) ? 2'b01 : 2'b10});
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_addr  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            cpu_wr    = 1'($urandom_range(0, 1));
            cpu_wdata = 8'($urandom);
            dbg_req   = ($urandom_range(0, 2) != 0);
            dbg_addr  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            dbg_wr    = 1'($urandom_range(0, 1));
            dbg_wdata = 8'($urandom);
            step();
            check("random", n, w_act, model_vec());
        end

        // Drain to idle and confirm it stays quiet.
        idle_inputs();
        for (int n = 0; n < 4; n++) begin
            step();
            check("drain", n, w_act, model_vec());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Arbitrates port b (the read/write port) of the CPU register file between two requesters: the CPU execute stage (`cpu_*`) and the host debug interface (`dbg_*`). The arbiter registers the winning request and drives `b_addr`, `b_data_in` and `b_wr_enable` for exactly one cycle per access. It captures `b_data_out` and returns it with a done pulse. The CPU has priority, but a hold counter guarantees that debug accesses cannot be starved. Writes to the FLAG register (address 31) are blocked and reported as errors.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive CPU grants while a debug request is pending; range 1..15.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request (level).
- `cpu_addr` in 5: CPU register address.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_wdata` in 8: CPU write data.
- `cpu_gnt` out 1: CPU request accepted; pulse during the access cycle.
- `cpu_done` out 1: CPU access complete; `rdata` and `err` are valid.
- `dbg_req`, `dbg_addr`, `dbg_wr`, `dbg_wdata`, `dbg_gnt`, `dbg_done`: same widths and meanings, for the debug requester.
- `rdata` out 8: register value captured during the access.
- `err` out 1: the completed access was a blocked write to FLAG.
- `b_addr` out 5: to register file `b_addr`.
- `b_data_in` out 8: to register file `b_data_in`.
- `b_wr_enable` out 1: to register file `b_wr_enable`.
- `b_data_out` in 8: from register file `b_data_out`.
- `busy` out 1: high while in ACCESS.

## Operation
- **States:**
  - IDLE: no access in progress.
  - ACCESS: port b is driven for the registered request.
- **Arbitration:** evaluated at every rising edge in either state.
  - No request: go to (or stay in) IDLE.
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless `hold_cnt == HOLD_MAX`, in which case debug wins.
- **Hold counter (`hold_cnt`):**
  - Increments (saturating at HOLD_MAX) when CPU wins while `dbg_req` is high.
  - Clears to 0 when debug wins, or at any edge where `dbg_req` is low.
- **On a win:** register the winner's addr, wr and wdata, plus a winner-id flag, then go to ACCESS.
- **ACCESS outputs:**
  - `b_addr` = registered addr.
  - `b_data_in` = registered wdata.
  - `b_wr_enable` = wr AND (addr != 31).
  - The winner's `gnt` = 1.
- **Completion:** at the edge ending ACCESS:
  - `rdata` <= `b_data_out`. This is the pre-write value for a write access.
  - The winner's `done` <= 1 for one cycle.
  - `err` <= wr AND (addr == 31).
  - Arbitration runs at the same edge, so ACCESS can repeat back-to-back.
- **Holding `req`:** a requester that keeps `req` high after `gnt` is treated as issuing a new request with the current addr/wr/wdata values.
- **Addresses 29 and 30 (GOUT, DOUT):** writable normally; no special handling.

## Timing
- **Reset values:** state IDLE, `hold_cnt` 0, and all outputs 0 (`b_addr`, `b_data_in`, `rdata`, `gnt`, `done`, `err`, `b_wr_enable`, `busy`).
- **Latency:** request sampled at edge E0 -> `gnt` and port b driven in cycle E0..E1 -> `done`/`rdata`/`err` in cycle E1..E2.
- **Throughput:** one access per cycle with continuous requests.
- `gnt` and `done` are never high for both requesters in the same cycle.
- `done` is high only in the cycle after that requester's `gnt`.
- When ACCESS is left for IDLE, `b_wr_enable` is 0 from the next cycle. Port b addr/data keep their last values.
- **Reset during ACCESS:**
  - The register file may still commit that cycle's write.
  - The arbiter produces no `done` and returns to IDLE with reset values.
- **Reset and `req` together:** the `req` is ignored; no grant on the cycle after reset.
- **Simultaneous requests with `hold_cnt` saturated:** debug is granted and `hold_cnt` clears the same edge.

## Test plan
- **Single CPU write:** `cpu_req` for one cycle, addr 5, wr 1, wdata 0xA5.
  - Next cycle: `cpu_gnt` = 1, `b_wr_enable` = 1, `b_addr` = 5, `b_data_in` = 0xA5.
  - Following cycle: `cpu_done` = 1, `err` = 0.
  - A subsequent read of addr 5 returns `rdata` = 0xA5.
- **Starvation guard (HOLD_MAX = 4):** `cpu_req` and `dbg_req` held continuously.
  - Grant sequence: CPU, CPU, CPU, CPU, DBG, CPU, CPU, CPU, CPU, DBG.
  - No cycle without a grant.
- **FLAG write block:** `dbg_req` with addr 31, wr 1, wdata 0xFF.
  - `dbg_gnt` = 1 and `b_wr_enable` = 0.
  - Next cycle: `dbg_done` = 1, `err` = 1, `rdata` = current FLAG value.
- **Back-to-back reads:** CPU reads addr 1 then 2 on consecutive cycles, with r1 = 0x11 and r2 = 0x22.
  - `cpu_gnt` is high for 2 cycles.
  - `cpu_done` is high for 2 cycles with `rdata` = 0x11 then 0x22.
  - `busy` stays high for exactly 2 cycles.
- **Reset mid-access:** assert `reset` during the ACCESS cycle of a debug read.
  - No `dbg_done`.
  - All outputs are 0 in the cycle after reset.
  - `hold_cnt` = 0: verified by 4 CPU grants before a debug grant under continuous requests.
- **Idle drop:** a single request followed by no requests.
  - `b_wr_enable`, `gnt` and `busy` return to 0 and stay there.
  - `done` pulses exactly once.
